// File: rtl/scratchpad_req_ctrl.sv
// rtl/scratchpad_req_ctrl.sv - single-outstanding request controller guarding a scratchpad window
module scratchpad_req_ctrl #(
    parameter int unsigned CHUNK_SIZE      = 512,
    parameter int unsigned NUM_CHUNKS      = 1024,
    parameter logic [63:0] SCRATCHPAD_BASE = 64'h0300000000000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_len,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_write,
    output logic        sp_en,
    output logic        sp_write,
    output logic [63:0] sp_addr,
    output logic [1:0]  sp_len,
    output logic [63:0] sp_wdata,
    input  logic [63:0] sp_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    // Window bounds are widened to 65 bits so neither subtraction nor end-of-access can wrap.
    localparam logic [64:0] SIZE = 65'(CHUNK_SIZE) * 65'(NUM_CHUNKS);
    localparam logic [64:0] BASE = {1'b0, SCRATCHPAD_BASE};

    state_t      state, state_next;
    logic [64:0] addr_ext, offset, len_bytes;
    logic        legal;
    logic        accept;

    always_comb begin
        addr_ext  = {1'b0, req_addr};
        len_bytes = 65'd1 << req_len;
        offset    = addr_ext - BASE;
        legal     = (addr_ext >= BASE)
                 && ((offset + len_bytes) <= SIZE)
                 && ((addr_ext & (len_bytes - 65'd1)) == 65'd0);
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = legal ? ACCESS : RESP;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so it is low for the whole reset pulse.
    always_comb begin
        req_ready = (state == IDLE) && rst_n;
        rsp_valid = (state == RESP);
        sp_en     = (state == ACCESS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
            rsp_write <= 1'b0;
            sp_write  <= 1'b0;
            sp_addr   <= 64'd0;
            sp_len    <= 2'd0;
            sp_wdata  <= 64'd0;
        end else begin
            if ((state == IDLE) && accept) begin
                rsp_write <= req_write;
                rsp_rdata <= 64'd0;
                rsp_err   <= !legal;
                // Illegal requests leave the scratchpad-side payload untouched.
                if (legal) begin
                    sp_write <= req_write;
                    sp_addr  <= req_addr;
                    sp_len   <= req_len;
                    sp_wdata <= req_wdata;
                end
            end
            if (state == CAPTURE) begin
                rsp_rdata <= sp_write ? 64'd0 : sp_rdata;
            end
        end
    end

endmodule

// File: doc/scratchpad_req_ctrl.md
SCRATCHPAD_REQ_CTRL -- requirements
Module: scratchpad_req_ctrl

Interface
REQ-001 SHALL have parameter CHUNK_SIZE, default 512, bytes per chunk.
REQ-002 SHALL have parameter NUM_CHUNKS, default 1024, chunk count; SIZE = CHUNK_SIZE*NUM_CHUNKS.
REQ-003 SHALL have parameter SCRATCHPAD_BASE, default 64'h0300000000000000, first valid byte address.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-007 SHALL have ports req_write in 1, req_addr in 64, req_len in 2, req_wdata in 64: request payload; len 00 byte, 01 half, 10 word, 11 double.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-009 SHALL have ports rsp_rdata out 64, rsp_err out 1, rsp_write out 1: response payload.
REQ-010 SHALL have ports sp_en out 1, sp_write out 1, sp_addr out 64, sp_len out 2, sp_wdata out 64, sp_rdata in 64: scratchpad side.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP.
REQ-012 IDLE: req_ready=1; on req_valid&req_ready latch payload; go ACCESS if legal, else RESP with rsp_err=1.
REQ-013 Legal SHALL mean addr >= BASE, (addr-BASE) + (1<<len) <= SIZE, and addr aligned to 1<<len bytes; compare in 65 bits, no wrap.
REQ-014 ACCESS: sp_en=1 for exactly one cycle with latched write/addr/len/wdata; next state CAPTURE.
REQ-015 CAPTURE: register sp_rdata into rsp_rdata for reads; rsp_rdata=0 for writes; next state RESP.
REQ-016 RESP: rsp_valid=1; rsp_rdata/rsp_err/rsp_write stable until rsp_valid&rsp_ready; then IDLE.
REQ-017 req_ready SHALL be 0 in ACCESS, CAPTURE, RESP; one outstanding request maximum.
REQ-018 Legal latency: request accept edge to rsp_valid = 3 cycles; illegal = 1 cycle.
REQ-019 Illegal requests SHALL never assert sp_en; rsp_rdata=0, rsp_err=1.
REQ-020 sp_en SHALL be 0 in every state but ACCESS; sp_* payload may hold last value.
REQ-021 rsp_write SHALL echo latched req_write, for legal and illegal requests.
REQ-022 rsp_ready asserted outside RESP SHALL be ignored.
REQ-023 Back-to-back: a new request SHALL be accepted no earlier than the cycle after the response handshake (IDLE cycle).

Reset
REQ-024 rst_n low SHALL force IDLE immediately, asynchronously, including mid-ACCESS.
REQ-025 Reset values: req_ready=0 while rst_n low, rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0, sp_en=0, sp_write=0, sp_addr=0, sp_len=0, sp_wdata=0.
REQ-026 A request interrupted by reset SHALL produce no response; scratchpad state for an ACCESS cut by reset is undefined.
REQ-027 req_ready SHALL rise the first cycle after rst_n deasserts.

Verification
REQ-028 Write double to 0x0300000000000010 data 0x1122334455667788, then read double same address -> sp_en one cycle each, read rsp_rdata=0x1122334455667788, rsp_err=0, latency 3.
REQ-029 Read byte at 0x02FFFFFFFFFFFFFF and double at 0x030000000007FFF8+8 (0x0300000000080000) -> rsp_err=1 after 1 cycle, sp_en never high.
REQ-030 Word at 0x0300000000000002 (misaligned) -> rsp_err=1; word at 0x030000000007FFFC -> legal, rsp_err=0.
REQ-031 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and payload stable, req_ready=0, no second sp_en; release -> IDLE next cycle.
REQ-032 Drop rst_n during ACCESS -> sp_en=0 and rsp_valid=0 immediately, no response after release, req_ready=1 one cycle after rst_n rises.
